// File: rtl/ace_pipe_ctrl.sv
// ace_pipe_ctrl: front-end/rename pipeline controller.
// Generates stage load enables, stage flushes and the backend stall from
// structural hazard inputs, sequences flush recovery (RAT/RFL restore) and
// keeps a saturating count of stalled RUN cycles.
module ace_pipe_ctrl #(
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             icache_stall_i,
    input  logic             decode_instbuf_full_i,
    input  logic             decode_instbuf_empty_i,
    input  logic             rename_specrfl_stall_i,
    input  logic             issue_full_i,
    input  logic             retire_flush_i,
    input  logic             perf_clr_i,
    output logic             pipe_stall_o,
    output logic             pipe_load_fetch_o,
    output logic             pipe_load_decode_o,
    output logic             pipe_load_rename_o,
    output logic             flush_fetch_o,
    output logic             flush_decode_o,
    output logic             flush_rename_o,
    output logic             retire_flush_r_o,
    output logic             recover_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    // Recovery counts down to zero, so RECOVER lasts RECOVER_CYCLES cycles.
    localparam logic [3:0] REC_LOAD = 4'(RECOVER_CYCLES - 1);

    logic [1:0]       state_q,   state_d;
    logic [3:0]       rec_cnt_q, rec_cnt_d;
    logic             retire_flush_r_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             hazard_stall;

    assign hazard_stall = rename_specrfl_stall_i | issue_full_i;

    // Next-state and recovery counter; a retire flush wins over everything.
    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        case (state_q)
            ST_INIT:    state_d = ST_RUN;
            ST_RUN:     state_d = ST_RUN;
            ST_FLUSH: begin
                state_d   = ST_RECOVER;
                rec_cnt_d = REC_LOAD;
            end
            ST_RECOVER: begin
                if (rec_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    rec_cnt_d = rec_cnt_q - 4'd1;
                end
            end
            default:    state_d = ST_INIT;
        endcase
        if (retire_flush_i) begin
            state_d = ST_FLUSH;
        end
    end

    // Stage controls: only RUN lets the pipe move; INIT and FLUSH flush all stages.
    always_comb begin
        pipe_stall_o       = 1'b1;
        pipe_load_fetch_o  = 1'b0;
        pipe_load_decode_o = 1'b0;
        pipe_load_rename_o = 1'b0;
        flush_fetch_o      = 1'b0;
        flush_decode_o     = 1'b0;
        flush_rename_o     = 1'b0;
        recover_busy_o     = 1'b1;
        case (state_q)
            ST_RUN: begin
                pipe_stall_o       = hazard_stall;
                pipe_load_rename_o = !hazard_stall && !decode_instbuf_empty_i;
                pipe_load_decode_o = !decode_instbuf_full_i;
                pipe_load_fetch_o  = !icache_stall_i && !decode_instbuf_full_i;
                recover_busy_o     = 1'b0;
            end
            ST_INIT, ST_FLUSH: begin
                flush_fetch_o  = 1'b1;
                flush_decode_o = 1'b1;
                flush_rename_o = 1'b1;
            end
            default: begin
                flush_fetch_o  = 1'b0;
                flush_decode_o = 1'b0;
                flush_rename_o = 1'b0;
            end
        endcase
    end

    // Stall counter: clear has priority, increment saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr_i) begin
            stall_cnt_d = '0;
        end else if ((state_q == ST_RUN) && hazard_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset overriding flush and clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_INIT;
            rec_cnt_q        <= '0;
            retire_flush_r_q <= 1'b0;
            stall_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            rec_cnt_q        <= rec_cnt_d;
            retire_flush_r_q <= retire_flush_i;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign retire_flush_r_o = retire_flush_r_q;
    assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_ace_pipe_ctrl.sv
// Testbench for ace_pipe_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a timestamp-based model of the controller.
module tb_ace_pipe_ctrl;

    localparam int RC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam int MD_INIT    = 0;
    localparam int MD_RUN     = 1;
    localparam int MD_FLUSH   = 2;
    localparam int MD_RECOVER = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, icache_stall, instbuf_full, instbuf_empty;
    logic          specrfl_stall, issue_full, retire_flush, perf_clr;
    logic          pipe_stall, ld_fetch, ld_decode, ld_rename;
    logic          fl_fetch, fl_decode, fl_rename, rflush_r, busy;
    logic [CW-1:0] stall_cnt;

    ace_pipe_ctrl #(.RECOVER_CYCLES(RC), .CNT_W(CW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .icache_stall_i         (icache_stall),
        .decode_instbuf_full_i  (instbuf_full),
        .decode_instbuf_empty_i (instbuf_empty),
        .rename_specrfl_stall_i (specrfl_stall),
        .issue_full_i           (issue_full),
        .retire_flush_i         (retire_flush),
        .perf_clr_i             (perf_clr),
        .pipe_stall_o           (pipe_stall),
        .pipe_load_fetch_o      (ld_fetch),
        .pipe_load_decode_o     (ld_decode),
        .pipe_load_rename_o     (ld_rename),
        .flush_fetch_o          (fl_fetch),
        .flush_decode_o         (fl_decode),
        .flush_rename_o         (fl_rename),
        .retire_flush_r_o       (rflush_r),
        .recover_busy_o         (busy),
        .stall_cnt_o            (stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: cycle index plus timestamps of the last reset and last flush.
    int cyc        = 0;
    int last_rst   = -100;
    int last_flush = -100;
    bit seen_rst   = 1'b0;
    bit exp_rfr    = 1'b0;
    int exp_cnt    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Mode of the current cycle derived purely from event history.
    function automatic int mode_now();
        if (last_rst == cyc - 1) return MD_INIT;
        if (last_flush > last_rst && (cyc - last_flush) <= 1 + RC)
            return ((cyc - last_flush) == 1) ? MD_FLUSH : MD_RECOVER;
        return MD_RUN;
    endfunction

    // Apply one cycle of inputs (called at posedge+1), check mid-cycle, advance model.
    task automatic run_cycle(input bit rst, input bit fl, input bit clr, input bit ic,
                             input bit full, input bit empty, input bit spec, input bit iss);
        int md;
        bit es;
        logic [2:0] eloads;
        logic [2:0] eflush;
        bit ebusy;
        reset         = rst;
        retire_flush  = fl;
        perf_clr      = clr;
        icache_stall  = ic;
        instbuf_full  = full;
        instbuf_empty = empty;
        specrfl_stall = spec;
        issue_full    = iss;
        #4;
        md = mode_now();
        es = 1'b1;
        eloads = 3'b000;
        eflush = 3'b000;
        ebusy = 1'b1;
        case (md)
            MD_RUN: begin
                es = spec | iss;
                eloads = {!ic && !full, !full, !es && !empty};
                ebusy = 1'b0;
            end
            MD_INIT, MD_FLUSH: eflush = 3'b111;
            default: eflush = 3'b000;
        endcase
        if (seen_rst) begin
            check_eq("pipe_stall", 32'(pipe_stall), 32'(es));
            check_eq("loads_fdr", 32'({ld_fetch, ld_decode, ld_rename}), 32'(eloads));
            check_eq("flush_fdr", 32'({fl_fetch, fl_decode, fl_rename}), 32'(eflush));
            check_eq("recover_busy", 32'(busy), 32'(ebusy));
            check_eq("retire_flush_r", 32'(rflush_r), 32'(exp_rfr));
            check_eq("stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
        end
        if (rst) exp_cnt = 0;
        else if (clr) exp_cnt = 0;
        else if (md == MD_RUN && es && exp_cnt < CMAX) exp_cnt++;
        exp_rfr = rst ? 1'b0 : fl;
        if (rst) begin
            last_rst = cyc;
            seen_rst = 1'b1;
        end else if (fl) begin
            last_flush = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit empty);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, empty, 0, 0);
    endtask

    initial begin
        reset = 1'b1; retire_flush = 1'b0; perf_clr = 1'b0; icache_stall = 1'b0;
        instbuf_full = 1'b0; instbuf_empty = 1'b1; specrfl_stall = 1'b0; issue_full = 1'b0;
        @(posedge clk);
        #1;
        // Reset two cycles, then INIT for one cycle and free-running RUN.
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3, 0);
        idle(2, 1);
        // Single flush from RUN, full recovery.
        run_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(6, 0);
        // Flush again during RECOVER.
        run_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2, 0);
        run_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(6, 0);
        // Back-to-back flushes.
        run_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        run_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(5, 0);
        // issue_full held five cycles with instruction buffer full.
        for (int i = 0; i < 5; i++) run_cycle(0, 0, 0, 0, 1, 0, 0, 1);
        run_cycle(0, 0, 1, 0, 0, 0, 0, 0);
        // Hold stall long enough to saturate the counter, then clear under stall.
        for (int i = 0; i < 20; i++) run_cycle(0, 0, 0, 1, 0, 0, 1, 0);
        run_cycle(0, 0, 1, 0, 0, 0, 1, 1);
        idle(2, 0);
        // Reset asserted mid-RECOVER, with a flush and clear alongside.
        run_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2, 0);
        run_cycle(1, 1, 1, 0, 0, 0, 1, 0);
        idle(3, 0);
        // Flush while in INIT.
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        idle(5, 0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            run_cycle($urandom_range(0, 99) < 2,
                      $urandom_range(0, 99) < 8,
                      $urandom_range(0, 99) < 5,
                      $urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 25,
                      $urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 30);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ace_pipe_ctrl.md
ACE_PIPE_CTRL -- requirements
Module: ace_pipe_ctrl

Interface
REQ-001 SHALL have parameter RECOVER_CYCLES, default 2, cycles of RAT/RFL restore after flush (range 1-15).
REQ-002 SHALL have parameter CNT_W, default 32, width of stall-cycle counter.
REQ-003 SHALL have clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have icache_stall_i  input  1  icache cannot supply fetch group.
REQ-006 SHALL have decode_instbuf_full_i  input  1  decode instruction buffer full.
REQ-007 SHALL have decode_instbuf_empty_i  input  1  decode instruction buffer empty.
REQ-008 SHALL have rename_specrfl_stall_i  input  1  speculative free list lacks registers.
REQ-009 SHALL have issue_full_i  input  1  issue queue cannot accept rename group.
REQ-010 SHALL have retire_flush_i  input  1  retire-stage flush pulse.
REQ-011 SHALL have perf_clr_i  input  1  clear stall counter.
REQ-012 SHALL have pipe_stall_o  output  1  backend stall to rename.
REQ-013 SHALL have pipe_load_fetch_o / pipe_load_decode_o / pipe_load_rename_o  output  1 each  stage load enables.
REQ-014 SHALL have flush_fetch_o / flush_decode_o / flush_rename_o  output  1 each  stage flush.
REQ-015 SHALL have retire_flush_r_o  output  1  retire_flush_i registered one cycle (drives arch RAT restore).
REQ-016 SHALL have recover_busy_o  output  1  high in INIT, FLUSH, RECOVER.
REQ-017 SHALL have stall_cnt_o  output  CNT_W  count of RUN cycles with pipe_stall_o high.

Function
REQ-018 SHALL implement FSM states INIT, RUN, FLUSH, RECOVER plus down-counter rec_cnt (4 bits).
REQ-019 INIT SHALL last exactly 1 cycle, then RUN unless retire_flush_i (then FLUSH).
REQ-020 In RUN: pipe_stall_o = rename_specrfl_stall_i | issue_full_i.
REQ-021 In RUN: pipe_load_rename_o = !pipe_stall_o & !decode_instbuf_empty_i.
REQ-022 In RUN: pipe_load_decode_o = !decode_instbuf_full_i.
REQ-023 In RUN: pipe_load_fetch_o = !icache_stall_i & !decode_instbuf_full_i.
REQ-024 Outputs of REQ-020..023 SHALL be combinational from state and inputs; flush_* = 0 in RUN.
REQ-025 retire_flush_i high in any state SHALL force next state FLUSH (highest priority).
REQ-026 FLUSH SHALL last 1 cycle per retire_flush_i cycle: flush_* = 1, all loads 0, pipe_stall_o = 1; next RECOVER with rec_cnt = RECOVER_CYCLES-1 unless retire_flush_i high again.
REQ-027 RECOVER: loads 0, pipe_stall_o = 1, flush_* = 0; rec_cnt decrements each cycle; at rec_cnt==0 next state RUN.
REQ-028 Flush during RECOVER SHALL abort recovery and re-enter FLUSH; counter reloads on next FLUSH exit.
REQ-029 In INIT: loads 0, pipe_stall_o = 1, flush_* = 1.
REQ-030 retire_flush_r_o SHALL equal retire_flush_i of the previous cycle in all states.
REQ-031 stall_cnt_o SHALL increment by 1 on each RUN cycle with pipe_stall_o = 1, saturating at all-ones (no wrap).
REQ-032 perf_clr_i SHALL zero stall_cnt_o next cycle, overriding a simultaneous increment.
REQ-033 A flush in RUN cycle N: flush_* high N+1, loads resume no earlier than N+2+RECOVER_CYCLES.

Reset
REQ-034 reset SHALL, next edge, set state INIT, rec_cnt 0, retire_flush_r_o 0, stall_cnt_o 0; hence pipe_stall_o 1, loads 0, flush_* 1, recover_busy_o 1.
REQ-035 reset SHALL override retire_flush_i and perf_clr_i, including mid-FLUSH/RECOVER.

Verification
REQ-036 Reset 2 cycles, release, all stall inputs 0 -> INIT 1 cycle, then RUN: loads fetch/decode 1, rename 1 when instbuf non-empty, stall 0.
REQ-037 RUN, retire_flush_i 1 cycle at N, RECOVER_CYCLES=2 -> flush_* 1 at N+1, RECOVER N+2..N+3, loads 1 at N+4; retire_flush_r_o 1 at N+1.
REQ-038 Flush again during RECOVER -> FLUSH re-entered next cycle, full 2-cycle RECOVER repeated before RUN.
REQ-039 RUN, issue_full_i held 5 cycles, instbuf full held -> pipe_stall_o 1, rename/decode/fetch loads 0; stall_cnt_o advances by 5.
REQ-040 Force stall_cnt_o to all-ones (CNT_W=4 build) with stall held -> stays 15; perf_clr_i with stall high -> 0 next cycle.
REQ-041 Assert reset during RECOVER -> INIT next cycle, counter 0, no RUN until INIT elapses.
